// File: rtl/traffic_light_pkg.sv
// Shared light-state codes and phase-duration lookup for the traffic light controller
// and the downstream display decoder.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_YELLOW = 2'b01,
    ST_GREEN  = 2'b10,
    ST_BAD    = 2'b11
  } light_state_t;

  function automatic int phase_time(light_state_t s, int red_t, int green_t, int yellow_t);
    case (s)
      ST_GREEN:  return green_t;
      ST_YELLOW: return yellow_t;
      default:   return red_t;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_controller_phase_timer.sv
// Phase down-counter: synchronous load has priority over decrement; zero flag marks the last tick.
module phase_timer #(
  parameter int               CNT_W   = 6,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_light_controller.sv
// RED -> GREEN -> YELLOW phase sequencer with registered countdown and phase-change pulse.
// Optional pedestrian shortening of GREEN is enabled by defining PED_REQUEST_EN.
module traffic_light_controller
  import traffic_light_pkg::*;
#(
  parameter int RED_TIME       = 30,
  parameter int GREEN_TIME     = 25,
  parameter int YELLOW_TIME    = 5,
  parameter int CNT_W          = 6,
  parameter int PED_MIN_REMAIN = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             enable,
`ifdef PED_REQUEST_EN
  input  logic             ped_req,
`endif
  output logic [1:0]       state,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_done
);

  if (RED_TIME < 1 || RED_TIME > 2**CNT_W || GREEN_TIME < 1 || GREEN_TIME > 2**CNT_W ||
      YELLOW_TIME < 1 || YELLOW_TIME > 2**CNT_W ||
      PED_MIN_REMAIN < 0 || PED_MIN_REMAIN >= 2**CNT_W) begin : g_bad_param
    $error("traffic_light_controller: phase time parameter out of range");
  end

  light_state_t     state_q;
  light_state_t     nxt;
  logic             illegal;
  logic             advance;
  logic             load;
  logic             dec;
  logic             zero;
  logic             ped_cut;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;

`ifdef PED_REQUEST_EN
  logic ped_pending;

  // A request in the same cycle as the cut counts immediately, so the cut lands one edge after ped_req.
  assign ped_cut = (state_q == ST_GREEN) && (ped_pending || ped_req) &&
                   (count > CNT_W'(PED_MIN_REMAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
    end else if (ped_req) begin
      ped_pending <= 1'b1;
    end else if ((advance || illegal) && nxt == ST_RED) begin
      ped_pending <= 1'b0;
    end
  end
`else
  assign ped_cut = 1'b0;
`endif

  always_comb begin
    nxt      = ST_RED;
    illegal  = 1'b0;
    case (state_q)
      ST_RED:    nxt = ST_GREEN;
      ST_GREEN:  nxt = ST_YELLOW;
      ST_YELLOW: nxt = ST_RED;
      default:   illegal = 1'b1;
    endcase

    load     = 1'b0;
    dec      = 1'b0;
    advance  = 1'b0;
    load_val = CNT_W'(RED_TIME - 1);
    if (illegal) begin
      load = 1'b1;
    end else if (ped_cut) begin
      load     = 1'b1;
      load_val = CNT_W'(PED_MIN_REMAIN);
    end else if (tick && enable) begin
      if (zero) begin
        load     = 1'b1;
        advance  = 1'b1;
        load_val = CNT_W'(phase_time(nxt, RED_TIME, GREEN_TIME, YELLOW_TIME) - 1);
      end else begin
        dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RED;
      phase_done <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      if (illegal || advance) begin
        state_q    <= nxt;
        phase_done <= 1'b1;
      end
    end
  end

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(RED_TIME - 1))
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .dec      (dec),
    .load_val (load_val),
    .count    (count),
    .zero     (zero)
  );

  assign state     = state_q;
  assign remaining = count;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed, table-driven bench for traffic_light_controller (RED=3, GREEN=2, YELLOW=1).
module tb_traffic_light_controller;
  import traffic_light_pkg::*;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick;
  logic         enable;
  logic [1:0]   state;
  logic [W-1:0] remaining;
  logic         phase_done;

  int n_checks = 0;
  int n_fail   = 0;
  int pd_count;

  always #5 clk = ~clk;

`ifdef PED_REQUEST_EN
  logic         ped_req;
  logic [1:0]   state2;
  logic [W-1:0] remaining2;
  logic         phase_done2;
`endif

  traffic_light_controller #(
    .RED_TIME(3), .GREEN_TIME(2), .YELLOW_TIME(1), .CNT_W(W), .PED_MIN_REMAIN(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
`ifdef PED_REQUEST_EN
    .ped_req(ped_req),
`endif
    .state(state), .remaining(remaining), .phase_done(phase_done)
  );

`ifdef PED_REQUEST_EN
  traffic_light_controller #(
    .RED_TIME(3), .GREEN_TIME(20), .YELLOW_TIME(1), .CNT_W(W), .PED_MIN_REMAIN(5)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable), .ped_req(ped_req),
    .state(state2), .remaining(remaining2), .phase_done(phase_done2)
  );
`endif

  typedef struct {
    logic       t;
    logic       e;
    logic [1:0] s;
    int         r;
    logic       pd;
  } vec_t;

  vec_t tbl[16];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(string tag, logic [1:0] s, int r, logic pd);
    check({tag, " state"}, 32'(state), 32'(s));
    check({tag, " remaining"}, 32'(remaining), 32'(r));
    check({tag, " phase_done"}, 32'(phase_done), 32'(pd));
  endtask

  // Called at a negedge; applies inputs across one rising edge and returns at the next negedge.
  task automatic cycle(logic t, logic e);
    tick   = t;
    enable = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    tick   = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] held_s [5];
    int         held_r [5];
    logic       held_pd[5];

`ifdef PED_REQUEST_EN
    ped_req = 1'b0;
`endif
    tbl[0]  = '{1'b1, 1'b1, ST_RED,    1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, ST_RED,    1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, ST_RED,    1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, ST_RED,    1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, ST_RED,    0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, ST_RED,    0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, ST_RED,    0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, ST_RED,    0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, ST_GREEN,  1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, ST_GREEN,  1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, ST_GREEN,  1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, ST_GREEN,  0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, ST_YELLOW, 0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, ST_YELLOW, 0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, ST_RED,    2, 1'b1};
    tbl[15] = '{1'b0, 1'b1, ST_RED,    2, 1'b0};

    held_s  = '{ST_RED, ST_RED, ST_GREEN, ST_GREEN, ST_YELLOW};
    held_r  = '{1, 0, 1, 0, 0};
    held_pd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n  = 1'b1;
    tick   = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    do_reset();
    check_out("reset", ST_RED, 2, 1'b0);

    // One full loop of the phase sequence
    pd_count = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].t, tbl[i].e);
      if (phase_done === 1'b1) pd_count++;
      check_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].r, tbl[i].pd);
    end
    check("phase_done pulses per loop", 32'(pd_count), 32'd3);

    // Freeze mid-GREEN with remaining=1 while tick keeps strobing
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    check_out("green entry", ST_GREEN, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0);
      check_out($sformatf("hold%0d", i), ST_GREEN, 1, 1'b0);
    end
    cycle(1'b1, 1'b1);
    check_out("resume", ST_GREEN, 0, 1'b0);

    // Asynchronous reset between edges while in YELLOW
    cycle(1'b1, 1'b1);
    check_out("yellow entry", ST_YELLOW, 0, 1'b1);
    tick = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async reset", ST_RED, 2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal state recovers to RED even with enable low
    cycle(1'b1, 1'b1);
    check_out("pre-upset", ST_RED, 1, 1'b0);
    force dut.state_q = ST_BAD;
    #1;
    release dut.state_q;
    cycle(1'b0, 1'b0);
    check_out("upset recovery", ST_RED, 2, 1'b1);
    cycle(1'b0, 1'b1);
    check_out("post-upset", ST_RED, 2, 1'b0);

    // tick held high for five cycles from the start of RED
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1);
      check_out($sformatf("held%0d", i), held_s[i], held_r[i], held_pd[i]);
    end

`ifdef PED_REQUEST_EN
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1);
    check("ped green state", 32'(state2), 32'(ST_GREEN));
    check("ped before cut", 32'(remaining2), 32'd15);
    ped_req = 1'b1;
    cycle(1'b0, 1'b1);
    ped_req = 1'b0;
    check("ped cut remaining", 32'(remaining2), 32'd5);
    check("ped pending set", 32'(dut2.ped_pending), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    check("ped green end", 32'(state2), 32'(ST_GREEN));
    check("ped green rem0", 32'(remaining2), 32'd0);
    cycle(1'b1, 1'b1);
    check("ped yellow", 32'(state2), 32'(ST_YELLOW));
    check("ped pending in yellow", 32'(dut2.ped_pending), 32'd1);
    cycle(1'b1, 1'b1);
    check("ped red", 32'(state2), 32'(ST_RED));
    check("ped pending cleared", 32'(dut2.ped_pending), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
